sw_cmd_scheduler: RTL

Control sequencer for the stopwatch counter datapath. It arbitrates commands from two requesters: front-panel buttons (edge-detected levels) and a host port (req/ack handshake). It runs the IDLE/RUNNING/PAUSED/CLEARING state machine and generates the per-second count enable and the synchronous clear for the seconds/minutes counters. It also detects counter saturation from the counter outputs fed back to it.

---
 rtl/sw_cmd_scheduler.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sw_cmd_scheduler.sv
// sw_cmd_scheduler: command arbiter and run-state sequencer for the stopwatch
// seconds/minutes counter. Panel buttons are edge-detected. The host port uses
// a req/ack handshake. The block produces the per-second count enable and the
// counter clear, and it flags saturation using the counter values fed back to it.
// Optional feature macro: SW_LAP_EN adds lap capture outputs (lap_min, lap_sec,
// lap_vld) and accepts the host LAP command.
module sw_cmd_scheduler #(
  parameter int TICK_DIV = 1,    // clocks per stopwatch second, 1..65536
  parameter int MAX_MIN  = 255   // minutes value at which counting saturates
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  input  logic       host_req,
  input  logic [1:0] host_cmd,
  output logic       host_ack,
  output logic       host_err,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [1:0] status,
`ifdef SW_LAP_EN
  output logic [7:0] lap_min,
  output logic [5:0] lap_sec,
  output logic       lap_vld,
`endif
  output logic       ovf
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_RUNNING  = 2'b01,
    S_PAUSED   = 2'b10,
    S_CLEARING = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    C_START = 2'b00,
    C_STOP  = 2'b01,
    C_RESET = 2'b10,
    C_LAP   = 2'b11
  } cmd_t;

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    MIN_SAT    = 8'(MAX_MIN);

  state_t        state;
  logic [PW-1:0] presc;
  logic          start_q, stop_q, reset_q;
  logic          guard;

  logic p_start, p_stop, p_rst;
  logic h_valid, h_rst;
  logic cmd_vld, host_take, host_rej;
  cmd_t cmd;
  logic tick_due, sat;

  // Panel commands fire on the first sampled high after a low sample.
  assign p_start = start & ~start_q;
  assign p_stop  = stop  & ~stop_q;
  assign p_rst   = reset & ~reset_q;

  // A host request is eligible only once per req assertion.
  assign h_valid = host_req & ~guard;
  assign h_rst   = h_valid & (host_cmd == C_RESET);

  // A tick becomes due on the last prescaler count while running. At MAX_MIN:59
  // the tick is swallowed so the counter holds at its ceiling.
  assign tick_due = (state == S_RUNNING) && (presc == PRESC_LAST);
  assign sat      = tick_due && (minutes == MIN_SAT) && (seconds == 6'd59);
  assign cnt_en   = tick_due && !sat;

  // CLEARING is reported as IDLE.
  assign status = (state == S_RUNNING) ? 2'b01 :
                  (state == S_PAUSED)  ? 2'b10 : 2'b00;

  // Arbitrate the single command that takes effect at the coming edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    cmd_vld   = 1'b0;
    cmd       = C_START;
    host_take = 1'b0;
    if (p_rst || h_rst) begin
      // RESET from either side wins. A host RESET is consumed even when the
      // panel reset arrives on the same edge.
      cmd_vld   = 1'b1;
      cmd       = C_RESET;
      host_take = h_rst;
    end else if (state != S_CLEARING) begin
      if (p_stop) begin
        cmd_vld = 1'b1;
        cmd     = C_STOP;
      end else if (p_start) begin
        cmd_vld = 1'b1;
        cmd     = C_START;
      end else if (h_valid) begin
        cmd_vld   = 1'b1;
        cmd       = cmd_t'(host_cmd);
        host_take = 1'b1;
      end
    end
  end

  // Decide whether an accepted host command is reported as rejected.
  always_comb begin
    host_rej = 1'b0;
    case (cmd)
      C_START: host_rej = (state == S_PAUSED) && ovf;
`ifdef SW_LAP_EN
      C_LAP:   host_rej = 1'b0;
`else
      C_LAP:   host_rej = 1'b1;
`endif
      default: host_rej = 1'b0;
    endcase
  end

  // Sequencer: edge registers, host handshake, run state, prescaler and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      presc    <= '0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      reset_q  <= 1'b0;
      guard    <= 1'b0;
      host_ack <= 1'b0;
      host_err <= 1'b0;
      cnt_clr  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments. Every right-hand
      // side then sees the values from before this edge, which avoids
      // order-dependent simulation and simulation/synthesis mismatch.
      start_q  <= start;
      stop_q   <= stop;
      reset_q  <= reset;
      host_ack <= host_take;
      host_err <= host_take && host_rej;
      guard    <= host_req ? (guard | host_take) : 1'b0;
      cnt_clr  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_vld && cmd == C_START) begin
            state <= S_RUNNING;
            presc <= '0;
          end
        end
        S_RUNNING: begin
          presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
          if (sat) begin
            state <= S_PAUSED;
            ovf   <= 1'b1;
          end else if (cmd_vld && cmd == C_STOP) begin
            state <= S_PAUSED;
          end
        end
        S_PAUSED: begin
          // The prescaler is left alone, so the partial second carries over.
          if (cmd_vld && cmd == C_START && !ovf)
            state <= S_RUNNING;
        end
        default: begin
          // S_CLEARING lasts one cycle.
          state <= S_IDLE;
          presc <= '0;
          ovf   <= 1'b0;
        end
      endcase

      if (cmd_vld && cmd == C_RESET) begin
        state   <= S_CLEARING;
        presc   <= '0;
        cnt_clr <= 1'b1;
      end
    end
  end

`ifdef SW_LAP_EN
  logic lap_hit;

  // A lap comes from host LAP, or from panel start while running.
  assign lap_hit = cmd_vld &&
                   ((cmd == C_LAP) ||
                    (cmd == C_START && !host_take && state == S_RUNNING));

  // Lap registers: capture the counter on the command edge, clear in CLEARING.
  always_ff @(posedge clk) begin
    if (rst || state == S_CLEARING) begin
      lap_min <= '0;
      lap_sec <= '0;
      lap_vld <= 1'b0;
    end else if (lap_hit) begin
      lap_min <= minutes;
      lap_sec <= seconds;
      lap_vld <= 1'b1;
    end
  end
`endif

endmodule
